// File: rtl/load_store_unit.sv
// Load/store unit: aligns and validates data-memory requests, runs one bus
// transaction per accepted access with a bounded wait, and formats load data.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] dAddr,
    input  logic [31:0] dWdata,
    output logic [31:0] dRdata,
    output logic        stall,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        accept_s;
    logic        timeout_s;
    logic        stall_s;
    logic        err_s;
    logic        we_r;
    logic [2:0]  f3_r;
    logic [1:0]  off_r;
    logic [7:0]  cnt_r;
    logic        timeout_r;
    logic [31:0] drdata_r;
    logic [31:0] addr_r;
    logic [3:0]  be_r;
    logic [31:0] wdata_r;

    // Legal size encoding with the address aligned to the access size.
    function automatic logic req_ok(input logic [2:0] f3, input logic [1:0] a);
        logic ok;
        case (f3)
            3'b000, 3'b100: ok = 1'b1;
            3'b001, 3'b101: ok = ~a[0];
            3'b010:         ok = (a == 2'b00);
            default:        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte lanes touched by the access.
    function automatic logic [3:0] calc_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across every lane so the byte enables pick it out.
    function automatic logic [31:0] calc_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Extract the addressed lane and sign/zero extend it.
    function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(rd >> {off, 3'b000});
        h = off[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    // Next-state logic plus the combinational stall/err handshake.
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        timeout_s = 1'b0;
        stall_s   = 1'b0;
        err_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_valid) begin
                    if (req_ok(funct3, dAddr[1:0])) begin
                        accept_s = 1'b1;
                        stall_s  = 1'b1;
                        state_s  = ACCESS;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                stall_s = 1'b1;
                if (bus_ack) begin
                    state_s = DONE;
                end else if ((cnt_r + 8'd1) == 8'(TIMEOUT_CYCLES)) begin
                    timeout_s = 1'b1;
                    state_s   = DONE;
                end else begin
                    state_s = ACCESS;
                end
            end
            DONE: begin
                // A mem_valid here belongs to the retiring instruction.
                err_s   = timeout_r;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, latched request, wait counter and load result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            we_r      <= 1'b0;
            f3_r      <= 3'b000;
            off_r     <= 2'b00;
            cnt_r     <= 8'd0;
            timeout_r <= 1'b0;
            drdata_r  <= 32'd0;
            addr_r    <= 32'd0;
            be_r      <= 4'b0000;
            wdata_r   <= 32'd0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                we_r      <= mem_we;
                f3_r      <= funct3;
                off_r     <= dAddr[1:0];
                addr_r    <= {dAddr[31:2], 2'b00};
                be_r      <= calc_be(funct3, dAddr[1:0]);
                wdata_r   <= calc_wdata(funct3, dWdata);
                cnt_r     <= 8'd0;
                timeout_r <= 1'b0;
            end else if (state_r == ACCESS) begin
                if (bus_ack) begin
                    if (!we_r) begin
                        drdata_r <= format_load(f3_r, off_r, bus_rdata);
                    end
                end else if (timeout_s) begin
                    timeout_r <= 1'b1;
                    if (!we_r) begin
                        drdata_r <= 32'd0;
                    end
                end else begin
                    cnt_r <= cnt_r + 8'd1;
                end
            end
        end
    end

    assign stall     = stall_s & ~reset;
    assign err       = err_s & ~reset;
    assign bus_req   = (state_r == ACCESS);
    assign bus_we    = we_r;
    assign bus_addr  = addr_r;
    assign bus_be    = be_r;
    assign bus_wdata = wdata_r;
    assign dRdata    = drdata_r;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16, number of ACCESS cycles without bus_ack before the access is abandoned (legal range 2..255).
REQ-002 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: mem_valid  input  1  a load or store is present this cycle.
REQ-005 Port: mem_we  input  1  1 = store, 0 = load.
REQ-006 Port: funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 Port: dAddr  input  32  byte address from the ALU.
REQ-008 Port: dWdata  input  32  store data (rs2).
REQ-009 Port: dRdata  output  32  formatted, extended load result to the register-write mux.
REQ-010 Port: stall  output  1  holds PC and register write while high.
REQ-011 Port: err  output  1  one-cycle pulse on misaligned, illegal-funct3 or timed-out access.
REQ-012 Port: bus_req  output  1  bus request, held until acknowledged.
REQ-013 Port: bus_we  output  1  bus write strobe.
REQ-014 Port: bus_addr  output  32  word-aligned address: {dAddr[31:2], 2'b00}.
REQ-015 Port: bus_be  output  4  byte enables.
REQ-016 Port: bus_wdata  output  32  lane-replicated store data.
REQ-017 Port: bus_ack  input  1  access complete; bus_rdata valid in the same cycle for loads.
REQ-018 Port: bus_rdata  input  32  raw word read from memory.

Function
REQ-019 The FSM SHALL have three states: IDLE, ACCESS, DONE.
REQ-020 In IDLE, mem_valid with a legal, aligned request SHALL latch we, funct3, address and data, drive stall=1 combinationally, and move to ACCESS.
REQ-021 Alignment SHALL be: B/BU any address; H/HU dAddr[0]=0; W dAddr[1:0]=00; funct3 011/110/111 is illegal.
REQ-022 In IDLE, a misaligned or illegal request SHALL pulse err for one cycle with stall=0, no bus_req and dRdata unchanged.
REQ-023 In ACCESS, bus_req=1 with bus_we, bus_addr, bus_be and bus_wdata stable from latched values, and stall=1.
REQ-024 Byte-enable rules: B -> 1<<addr[1:0]; H -> 0011 if addr[1]=0, else 1100; W -> 1111.
REQ-025 bus_wdata rules: B -> {4{data[7:0]}}; H -> {2{data[15:0]}}; W -> data.
REQ-026 In ACCESS, bus_ack=1 SHALL move to DONE; for loads, the selected lane of bus_rdata SHALL be registered into dRdata: B/H sign-extended, BU/HU zero-extended, W unchanged.
REQ-027 A wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without ack.
REQ-028 When the counter reaches TIMEOUT_CYCLES, the FSM SHALL drop bus_req, load dRdata=0 for loads, pulse err in DONE, and move to DONE.
REQ-029 In DONE, stall=0, bus_req=0, and the FSM SHALL return to IDLE unconditionally; the pending instruction retires on this edge.
REQ-030 A mem_valid seen in DONE SHALL NOT be accepted (it is the retiring instruction).
REQ-031 bus_ack outside ACCESS SHALL be ignored.
REQ-032 dRdata SHALL hold its value until the next successful or timed-out load; stores never alter it.
REQ-033 Latency: zero-wait memory (ack on the first ACCESS cycle) gives 2 stall cycles per access; each wait cycle adds 1.

Reset
REQ-034 While reset is high: state=IDLE, dRdata=0, counter=0, stall=0, err=0, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0; all take effect immediately, without a clock edge.
REQ-035 A reset asserted during ACCESS SHALL drop bus_req asynchronously and abandon the access with no err pulse.

Verification
REQ-036 SB with dAddr=0x103, dWdata=0x000000A5, ack after 1 cycle -> bus_addr=0x100, bus_be=1000, bus_wdata=0xA5A5A5A5, stall high for 2 cycles.
REQ-037 LB, then LBU, with dAddr=0x202, bus_rdata=0x12F0_3456 -> dRdata=0xFFFFFFF0 for LB and 0x000000F0 for LBU.
REQ-038 LH with dAddr=0x2, bus_rdata=0x8001_0000 -> bus_be=1100, dRdata=0xFFFF8001; LW with dAddr=0x6 -> err pulse, no bus_req, dRdata unchanged.
REQ-039 LW with TIMEOUT_CYCLES=4 and bus_ack held 0 -> bus_req high for 4 cycles, then DONE with err=1, dRdata=0, then IDLE.
REQ-040 SW accepted, reset pulsed on the second ACCESS cycle -> bus_req=0 immediately, all outputs at reset values, the next LW completes normally.
REQ-041 Back-to-back LW/SW with an ack pulse injected while in IDLE -> stray ack ignored, each access produces exactly one bus_req burst.
